// File: rtl/router_mon_pkg.sv
// Shared constants, header layout and FSM encoding for the router protocol monitor.
package router_mon_pkg;

  // Bit positions inside viol_flags
  localparam int unsigned V_RESET     = 0;
  localparam int unsigned V_BUSY_HDR  = 1;
  localparam int unsigned V_STABLE    = 2;
  localparam int unsigned V_VALID_OUT = 3;
  localparam int unsigned V_READ_TO   = 4;
  localparam int unsigned V_PARITY    = 5;
  localparam int unsigned V_LENGTH    = 6;
  localparam int unsigned V_ADDR      = 7;
  localparam int unsigned NUM_VIOL    = 8;

  // Header byte layout: [1:0] destination, [DATA_W-1:2] payload length
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned LEN_LSB  = 2;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PARITY_WAIT,
    ERR_CHECK
  } mon_state_e;

endpackage

// File: rtl/router_mon_timeout.sv
// Single-channel read-timeout tracker: arms on a vld rise, fires if no read within READ_TIMEOUT cycles.
module router_mon_timeout #(
  parameter int unsigned READ_TIMEOUT = 30
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld_i,
  input  logic read_enb_i,
  output logic timeout_c
);

  localparam int unsigned TW = $clog2(READ_TIMEOUT + 1);

  logic          vld_q;
  logic          armed_q, armed_d;
  logic [TW-1:0] cnt_q, cnt_d, cnt_inc;

  // Arm / count / disarm decision; a read beats a falling vld, which beats expiry
  always_comb begin
    armed_d   = armed_q;
    cnt_d     = cnt_q;
    timeout_c = 1'b0;
    cnt_inc   = cnt_q + TW'(1);
    if (armed_q) begin
      if (read_enb_i || !vld_i) begin
        armed_d = 1'b0;
      end else if (cnt_inc == TW'(READ_TIMEOUT)) begin
        timeout_c = 1'b1;
        armed_d   = 1'b0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (vld_i && !vld_q) begin
      armed_d = 1'b1;
      cnt_d   = '0;
    end
  end

  // Tracker state registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_q   <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_i;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/router_protocol_monitor.sv
// Protocol monitor for the N-output packet router: temporal and packet-level checks with sticky flags/counters.
module router_protocol_monitor
  import router_mon_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_TIMEOUT = 30,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     pkt_valid,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     busy,
  input  logic                     err,
  input  logic [NUM_CH-1:0]        vld_out,
  input  logic [NUM_CH-1:0]        read_enb,
  input  logic [NUM_CH*DATA_W-1:0] data_out,
  input  logic                     clr_flags,
  output logic [NUM_VIOL-1:0]      viol_flags,
  output logic [NUM_CH-1:0]        timeout_ch,
  output logic                     viol_pulse,
  output logic [CNT_W-1:0]         viol_count,
  output logic [CNT_W-1:0]         pkt_count
);

  localparam int unsigned LEN_W = DATA_W - LEN_LSB;
  localparam int unsigned NV_W  = $clog2(NUM_VIOL + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  mon_state_e          state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   bcnt_q, bcnt_d;
  logic [DATA_W-1:0]   parity_q, parity_d;
  logic                par_bad_q, par_bad_d;
  logic                ec_q, ec_d;

  logic                post_reset_q, pv_q, busy_q1, busy_q2;
  logic [DATA_W-1:0]   din_q;
  logic [2:0]          rise_q;

  logic [NUM_VIOL-1:0] viol_flags_q, viol_flags_d;
  logic [NUM_CH-1:0]   timeout_ch_q, timeout_ch_d;
  logic                viol_pulse_q;
  logic [CNT_W-1:0]    viol_count_q, viol_count_d, vc_base;
  logic [CNT_W-1:0]    pkt_count_q, pkt_count_d, pc_base;
  logic [SUM_W-1:0]    vc_sum;
  logic [NV_W-1:0]     nviol;

  logic                rise, accept, load_hdr, pkt_done;
  logic                v_len, v_par, v_addr;
  logic [NUM_VIOL-1:0] viol;
  logic [NUM_CH-1:0]   tmo_c;

  // One read-timeout tracker per output channel
  for (genvar i = 0; i < NUM_CH; i++) begin : g_to
    router_mon_timeout #(.READ_TIMEOUT(READ_TIMEOUT)) u_to (
      .clock      (clock),
      .resetn     (resetn),
      .vld_i      (vld_out[i]),
      .read_enb_i (read_enb[i]),
      .timeout_c  (tmo_c[i])
    );
  end

  // Packet FSM: header latch, payload parity/length accumulation, deferred err check
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    bcnt_d    = bcnt_q;
    parity_d  = parity_q;
    par_bad_d = par_bad_q;
    ec_d      = ec_q;
    load_hdr  = 1'b0;
    pkt_done  = 1'b0;
    v_len     = 1'b0;
    v_par     = 1'b0;
    v_addr    = 1'b0;
    accept    = (pkt_valid || state_q == PARITY_WAIT) && !busy;
    case (state_q)
      IDLE: begin
        if (accept && pkt_valid) load_hdr = 1'b1;
      end
      PAYLOAD: begin
        if (!pkt_valid) begin
          state_d = PARITY_WAIT;
        end else if (accept) begin
          parity_d = parity_q ^ data_in;
          bcnt_d   = bcnt_q + DATA_W'(1);
        end
      end
      PARITY_WAIT: begin
        if (accept) begin
          v_len     = (bcnt_q != DATA_W'(len_q));
          par_bad_d = (parity_q != data_in);
          ec_d      = 1'b0;
          state_d   = ERR_CHECK;
        end
      end
      ERR_CHECK: begin
        if (!ec_q) begin
          ec_d = 1'b1;
        end else begin
          v_par    = (err != par_bad_q);
          pkt_done = 1'b1;
          state_d  = IDLE;
          // a header held across the check starts the next packet
          if (pkt_valid) load_hdr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_hdr) begin
      state_d  = PAYLOAD;
      len_d    = data_in[DATA_W-1:LEN_LSB];
      bcnt_d   = '0;
      parity_d = data_in;
      v_addr   = (32'(data_in[ADDR_LSB +: ADDR_W]) >= NUM_CH);
    end
  end

  // Violation vector for this cycle plus next values of sticky flags and counters
  always_comb begin
    rise                = pkt_valid && !pv_q;
    viol                = '0;
    viol[V_RESET]       = post_reset_q && ((|vld_out) || (|data_out));
    viol[V_BUSY_HDR]    = rise_q[1] && (busy_q2 || !busy_q1 || busy);
    viol[V_STABLE]      = busy_q1 && (data_in != din_q);
    viol[V_VALID_OUT]   = rise_q[2] && !(|vld_out);
    viol[V_READ_TO]     = |tmo_c;
    viol[V_PARITY]      = v_par;
    viol[V_LENGTH]      = v_len;
    viol[V_ADDR]        = v_addr;

    nviol = '0;
    for (int i = 0; i < NUM_VIOL; i++) nviol = nviol + NV_W'(viol[i]);

    vc_base      = clr_flags ? '0 : viol_count_q;
    vc_sum       = {1'b0, vc_base} + SUM_W'(nviol);
    viol_count_d = vc_sum[CNT_W] ? '1 : vc_sum[CNT_W-1:0];

    pc_base      = clr_flags ? '0 : pkt_count_q;
    pkt_count_d  = (pkt_done && pc_base != '1) ? pc_base + CNT_W'(1) : pc_base;

    viol_flags_d = (clr_flags ? '0 : viol_flags_q) | viol;
    timeout_ch_d = (clr_flags ? '0 : timeout_ch_q) | tmo_c;
  end

  // FSM, input history and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      bcnt_q       <= '0;
      parity_q     <= '0;
      par_bad_q    <= 1'b0;
      ec_q         <= 1'b0;
      post_reset_q <= 1'b1;
      pv_q         <= 1'b0;
      busy_q1      <= 1'b0;
      busy_q2      <= 1'b0;
      din_q        <= '0;
      rise_q       <= '0;
      viol_flags_q <= '0;
      timeout_ch_q <= '0;
      viol_pulse_q <= 1'b0;
      viol_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bcnt_q       <= bcnt_d;
      parity_q     <= parity_d;
      par_bad_q    <= par_bad_d;
      ec_q         <= ec_d;
      post_reset_q <= 1'b0;
      pv_q         <= pkt_valid;
      busy_q1      <= busy;
      busy_q2      <= busy_q1;
      din_q        <= data_in;
      rise_q       <= {rise_q[1:0], rise};
      viol_flags_q <= viol_flags_d;
      timeout_ch_q <= timeout_ch_d;
      viol_pulse_q <= |viol;
      viol_count_q <= viol_count_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign viol_flags = viol_flags_q;
  assign timeout_ch = timeout_ch_q;
  assign viol_pulse = viol_pulse_q;
  assign viol_count = viol_count_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_router_protocol_monitor.sv
// Directed bench for router_protocol_monitor; violation pulses are checked against a scoreboard queue.
module tb_router_protocol_monitor;

  logic        clock = 1'b0;
  logic        resetn, pkt_valid, busy, err, clr_flags;
  logic [7:0]  data_in;
  logic [2:0]  vld_out, read_enb;
  logic [23:0] data_out;
  logic [7:0]  viol_flags;
  logic [2:0]  timeout_ch;
  logic        viol_pulse;
  logic [15:0] viol_count, pkt_count;

  router_protocol_monitor #(
    .NUM_CH(3), .DATA_W(8), .READ_TIMEOUT(30), .CNT_W(16)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .busy       (busy),
    .err        (err),
    .vld_out    (vld_out),
    .read_enb   (read_enb),
    .data_out   (data_out),
    .clr_flags  (clr_flags),
    .viol_flags (viol_flags),
    .timeout_ch (timeout_ch),
    .viol_pulse (viol_pulse),
    .viol_count (viol_count),
    .pkt_count  (pkt_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          edge_n;
    logic [7:0]  flags;
    logic [15:0] cnt;
    logic [2:0]  tmo;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mx;
  int          ecnt   = 0;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          e0;
  logic [7:0]  m_flags = '0;
  logic [15:0] m_cnt   = '0;
  logic [2:0]  m_tmo   = '0;
  logic [15:0] m_pkt   = '0;
  logic [7:0]  pl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Expected pulse at edge e; accumulates the sticky model
  function automatic void push_viol(input int e, input logic [7:0] vec, input logic [2:0] t);
    exp_t x;
    m_flags = m_flags | vec;
    m_tmo   = m_tmo | t;
    for (int i = 0; i < 8; i++) if (vec[i]) m_cnt = m_cnt + 16'd1;
    x.edge_n = e; x.flags = m_flags; x.cnt = m_cnt; x.tmo = m_tmo;
    exp_q.push_back(x);
  endfunction

  function automatic void model_clr();
    m_flags = '0; m_cnt = '0; m_tmo = '0; m_pkt = '0;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  // Router-style packet: header, busy in the next cycle, payload, parity after pkt_valid falls
  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par,
                          input logic err_v, input logic [2:0] vmask,
                          input int rd_k, input int clr_k);
    for (int k = 0; k <= n + 5; k++) begin
      pkt_valid = (k <= n + 1);
      if (k == 0)          data_in = hdr;
      else if (k == 1)     data_in = pl[0];
      else if (k <= n + 1) data_in = pl[k-2];
      else                 data_in = par;
      busy      = (k == 1);
      vld_out   = (k >= 3) ? vmask : 3'b000;
      read_enb  = (k == rd_k) ? vmask : 3'b000;
      err       = (k == n + 5) ? err_v : 1'b0;
      clr_flags = (k == clr_k);
      tick();
    end
    pkt_valid = 1'b0; busy = 1'b0; err = 1'b0; clr_flags = 1'b0;
    read_enb = '0; vld_out = '0; data_in = '0;
  endtask

  // Monitor: every viol_pulse must match the next scoreboard entry
  initial begin
    forever begin
      @(posedge clock);
      ecnt = ecnt + 1;
      #1;
      if (viol_pulse === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pulse: edge %0d flags %0h count %0d", ecnt, viol_flags, viol_count);
        end else begin
          mx = exp_q.pop_front();
          chk("pulse_edge",  ecnt,       mx.edge_n);
          chk("pulse_flags", viol_flags, mx.flags);
          chk("pulse_count", viol_count, mx.cnt);
          chk("pulse_tmo",   timeout_ch, mx.tmo);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; busy = 1'b0; err = 1'b0; clr_flags = 1'b0;
    data_in = '0; vld_out = '0; read_enb = '0; data_out = 24'h005500;
    repeat (3) tick();

    // Reset state
    chk("rst_flags", viol_flags, 8'h00);
    chk("rst_tmo",   timeout_ch, 3'b000);
    chk("rst_pulse", viol_pulse, 1'b0);
    chk("rst_vcnt",  viol_count, 16'd0);
    chk("rst_pcnt",  pkt_count,  16'd0);

    // Release with lane 1 non-zero
    resetn = 1'b1;
    push_viol(ecnt + 1, 8'h01, 3'b000);
    tick();
    data_out = '0;
    repeat (3) tick();
    chk("reset_flag",  viol_flags, 8'h01);
    chk("reset_count", viol_count, 16'd1);
    model_clr();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
    chk("clr_flags", viol_flags, 8'h00);
    chk("clr_count", viol_count, 16'd0);

    // Legal packet to channel 1, read 5 cycles after vld_out
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h00;
    send_pkt(8'h0D, 3, 8'h0D, 1'b0, 3'b010, 8, -1);
    m_pkt = m_pkt + 16'd1;
    tick();
    chk("legal_pkt_count", pkt_count,  m_pkt);
    chk("legal_flags",     viol_flags, 8'h00);

    // Channel 2 never read: timeout exactly 30 cycles after rise
    vld_out = 3'b100;
    push_viol(ecnt + 1 + 30, 8'h10, 3'b100);
    repeat (35) tick();
    chk("to_tmo",   timeout_ch, 3'b100);
    chk("to_flags", viol_flags, 8'h10);
    vld_out = '0; repeat (2) tick();
    // Read on the last allowed cycle: no violation
    vld_out = 3'b100;
    for (int k = 0; k <= 32; k++) begin
      read_enb = (k == 30) ? 3'b100 : 3'b000;
      tick();
    end
    vld_out = '0; read_enb = '0; tick();
    chk("late_read_count", viol_count, 16'd1);

    // Length 3 header with 4 payload bytes and wrong parity byte
    model_clr();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    e0 = ecnt + 1;
    push_viol(e0 + 7, 8'h40, 3'b000);
    push_viol(e0 + 9, 8'h20, 3'b000);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    send_pkt(8'h0C, 4, 8'h00, 1'b0, 3'b001, 6, -1);
    m_pkt = m_pkt + 16'd1;
    tick();
    chk("badpkt_flags", viol_flags, 8'h60);
    chk("badpkt_count", viol_count, 16'd2);
    chk("badpkt_pkts",  pkt_count,  m_pkt);

    // Destination 3 with only 3 channels
    e0 = ecnt + 1;
    push_viol(e0, 8'h80, 3'b000);
    pl[0] = 8'h03;
    send_pkt(8'h03, 0, 8'h03, 1'b0, 3'b001, 4, -1);
    m_pkt = m_pkt + 16'd1;
    tick();
    chk("addr_flags", viol_flags, 8'hE0);

    // data_in changes the cycle after busy
    busy = 1'b1; data_in = 8'h5A;
    e0 = ecnt + 1;
    tick();
    busy = 1'b0; data_in = 8'hA5;
    push_viol(e0 + 1, 8'h04, 3'b000);
    tick();
    data_in = '0; tick();
    chk("stable_flags", viol_flags, 8'hE4);
    chk("stable_count", viol_count, 16'd4);
    chk("stable_pkts",  pkt_count,  m_pkt);

    // clr_flags coincident with a VALID_OUT violation
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h00;
    e0 = ecnt + 1;
    model_clr();
    push_viol(e0 + 3, 8'h08, 3'b000);
    send_pkt(8'h0D, 3, 8'h0D, 1'b0, 3'b000, -1, 3);
    m_pkt = m_pkt + 16'd1;
    tick();
    chk("clrvo_flags", viol_flags, 8'h08);
    chk("clrvo_count", viol_count, 16'd1);
    chk("clrvo_pkts",  pkt_count,  m_pkt);

    // Reset mid-payload aborts the packet
    pkt_valid = 1'b1; data_in = 8'h0D; busy = 1'b0; tick();
    data_in = 8'h01; busy = 1'b1; tick();
    busy = 1'b0; tick();
    data_in = 8'h02; vld_out = 3'b010; tick();
    resetn = 1'b0; pkt_valid = 1'b0; data_in = '0; vld_out = '0;
    model_clr();
    #1;
    chk("abort_flags", viol_flags, 8'h00);
    chk("abort_count", viol_count, 16'd0);
    chk("abort_pkts",  pkt_count,  16'd0);
    chk("abort_pulse", viol_pulse, 1'b0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (12) tick();
    chk("post_abort_flags", viol_flags, 8'h00);
    chk("post_abort_count", viol_count, 16'd0);
    chk("post_abort_pkts",  pkt_count,  16'd0);

    repeat (3) tick();
    while (exp_q.size() != 0) begin
      mx = exp_q.pop_front();
      n_chk++; n_fail++;
      $display("FAIL missing_pulse: got none, expected flags %0h at edge %0d", mx.flags, mx.edge_n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
